// File: rtl/vga_pkg.sv
// Shared XGA (1024x768 @ 60 Hz) raster constants and counter type for the vga_bus pipeline.
package vga_pkg;

  localparam int unsigned CNT_W = 11;
  typedef logic [CNT_W-1:0] vga_cnt_t;

  localparam int unsigned H_ACTIVE_DEF = 1024;
  localparam int unsigned H_FP_DEF     = 24;
  localparam int unsigned H_SYNC_DEF   = 136;
  localparam int unsigned H_BP_DEF     = 160;
  localparam int unsigned H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_ACTIVE_DEF = 768;
  localparam int unsigned V_FP_DEF     = 3;
  localparam int unsigned V_SYNC_DEF   = 6;
  localparam int unsigned V_BP_DEF     = 29;
  localparam int unsigned V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam logic [11:0] RGB_BLACK = 12'h000;

endpackage

// File: rtl/vga_bus_if.sv
// Raster bus passed between the timing source and the drawing stages.
interface vga_bus;
  import vga_pkg::*;

  vga_cnt_t    hcount;
  vga_cnt_t    vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus blank/sync decode, registered from the next count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned FP     = H_FP_DEF,
  parameter int unsigned SYNC   = H_SYNC_DEF,
  parameter int unsigned BP     = H_BP_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  output vga_cnt_t cnt,
  output logic     wrap,
  output logic     blnk,
  output logic     sync
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

  localparam vga_cnt_t LAST     = vga_cnt_t'(TOTAL - 1);
  localparam vga_cnt_t BLNK_ON  = vga_cnt_t'(ACTIVE);
  localparam vga_cnt_t SYNC_ON  = vga_cnt_t'(ACTIVE + FP);
  localparam vga_cnt_t SYNC_OFF = vga_cnt_t'(ACTIVE + FP + SYNC);

  vga_cnt_t cnt_next;
  logic     at_last;

  always_comb begin
    at_last  = (cnt == LAST);
    wrap     = en && at_last;
    cnt_next = cnt;
    if (en) begin
      cnt_next = at_last ? '0 : cnt + vga_cnt_t'(1);
    end
  end

  // Flags decode the next count so they line up with the count they are registered beside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      blnk <= 1'b0;
      sync <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      blnk <= (cnt_next >= BLNK_ON);
      sync <= (cnt_next >= SYNC_ON) && (cnt_next < SYNC_OFF);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// XGA raster source for the vga_bus pipeline; rgb leaves black.
// Optional completed-frame counter port enabled by VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  vga_bus.master      bus_out,
  output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  logic h_wrap;
  logic v_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .cnt  (bus_out.hcount),
    .wrap (h_wrap),
    .blnk (bus_out.hblnk),
    .sync (bus_out.hsync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v (
    .clk  (clk),
    .rst  (rst),
    .en   (h_wrap),
    .cnt  (bus_out.vcount),
    .wrap (v_wrap),
    .blnk (bus_out.vblnk),
    .sync (bus_out.vsync)
  );

  assign bus_out.rgb = RGB_BLACK;

  // v_wrap only fires on the last pixel of the frame, so the next position is exactly (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= v_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (v_wrap) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Source end of the `vga_bus` pipeline. It generates the 1024x768 @ 60 Hz (XGA) raster, driving `hcount`, `vcount`, `hsync`, `vsync`, `hblnk` and `vblnk` into the first draw stage. Every downstream drawing stage, including the board and text overlays, consumes these signals. `rgb` leaves this block as black, and the drawing stages overwrite it.

## Interface
Parameters:
- `H_ACTIVE`, 1024: visible pixels per line
- `H_FP`, 24: horizontal front porch
- `H_SYNC`, 136: horizontal sync width
- `H_BP`, 160: horizontal back porch; line total is 1344
- `V_ACTIVE`, 768: visible lines
- `V_FP`, 3: vertical front porch
- `V_SYNC`, 6: vertical sync width
- `V_BP`, 29: vertical back porch; frame total is 806

Ports:
- `clk`  in  1  pixel clock, 65 MHz
- `rst`  in  1  reset, asynchronous, active-high
- `bus_out`  out  vga_bus  `hcount`[10:0], `vcount`[10:0], `hsync`, `vsync`, `hblnk`, `vblnk`, `rgb`[11:0]
- `frame_start`  out  1  one-cycle pulse while `bus_out` shows pixel (0,0)
- `frame_cnt`  out  16  completed-frame counter; present only with `VGA_TIMING_FRAME_CNT_EN`

## Operation
- There are two counters. `hcount` runs from 0 to H_TOTAL-1 (1343) and wraps to 0. `vcount` advances only on the `hcount` wrap and runs from 0 to V_TOTAL-1 (805) before wrapping to 0.
- All `bus_out` fields and `frame_start` are registered. They are computed from the next counter values, so every field is consistent with the `hcount`/`vcount` shown in the same cycle.
- Decode rules, with half-open ranges and all flags active-high:
  - `hblnk` = `hcount` ∈ [1024,1344)
  - `hsync` = `hcount` ∈ [1048,1184)
  - `vblnk` = `vcount` ∈ [768,806)
  - `vsync` = `vcount` ∈ [771,777)
  - Sync polarity inversion for the connector is done at the top level, not in this block.
- `rgb` is always 12'h000.
- `frame_start` = (`hcount`==0 && `vcount`==0).
- Arithmetic: the counters are 11-bit unsigned. Compare each counter against H_TOTAL-1 / V_TOTAL-1 before incrementing. The counters never reach 2047 and never take values ≥ their total.
- Simultaneous wrap at (1343,805): both counters go to 0 in the same cycle, and `frame_start` asserts that cycle.
- Reset mid-frame: the counters return to (0,0) asynchronously and the frame restarts from the top-left. No partial-line completion.

## Timing
- Reset values: `hcount`=0, `vcount`=0, `hsync`=`vsync`=`hblnk`=`vblnk`=0, `rgb`=0, `frame_start`=0, `frame_cnt`=0.
- First rising edge after `rst` falls: `hcount`=1.
- The first `frame_start` pulse comes at the start of the second frame, 1344×806 = 1,083,264 cycles after reset release. The reset-state (0,0) does not pulse.
- Latency is zero: the decode flags change in the same cycle as the counter value that causes them.
- Line period is 1344 cycles and frame period is 1,083,264 cycles. These are exact, with no jitter.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN`
  - Defined: the `frame_cnt` port and register exist. The counter increments by 1 in the cycle `frame_start` asserts and wraps from 16'hFFFF to 0.
  - Undefined: the port and logic are absent. All other behaviour is identical.

## Structure
- Shared package `vga_pkg`:
  - all H_*/V_* default constants
  - H_TOTAL and V_TOTAL
  - counter width (11)
  - `typedef logic [10:0] vga_cnt_t`
- One sub-module, `vga_axis_counter`, instantiated twice (horizontal and vertical). It contains:
  - a wrapping counter with a count-enable input and a `wrap` output
  - a parameterised ACTIVE/FP/SYNC decode producing `blnk`/`sync`
- The top level chains `wrap` of the horizontal instance to the enable of the vertical instance and generates `frame_start`/`frame_cnt`.

## Test plan
- Reset release: hold `rst` for 5 cycles, then release. Required response: `hcount`=0/`vcount`=0 with all flags 0 during reset; `hcount`=1 on the first edge after release.
- Horizontal line: step through one line. Required response:
  - `hblnk` rises exactly at `hcount`=1024 and falls at 0.
  - `hsync` is high for `hcount` 1048–1183 (136 cycles).
  - `hcount` goes 1343→0 while `vcount` goes 0→1.
- Full frame: run 1,083,264 cycles. Required response:
  - `vblnk` high for `vcount` 768–805.
  - `vsync` high for `vcount` 771–776, 6 lines = 8064 cycles.
  - Exactly one `frame_start` pulse, at (0,0).
- Asynchronous reset mid-frame: assert `rst` between clock edges at (500,300). Required response: outputs are (0,0) with flags 0 before the next edge; counting restarts from 1 after release.
- With `VGA_TIMING_FRAME_CNT_EN`: run 3 frames. Required response: `frame_cnt` reads 0, 1, 2, incrementing in the `frame_start` cycles. Force `frame_cnt`=16'hFFFF; the next frame wraps it to 0.
